// File: rtl/program_loader.sv
// Boot loader: packs big-endian UART byte pairs into 16-bit words and writes them to sequential program memory addresses.
// Latency: the write strobe rises one cycle after the low byte arrives, and the address advances on the following edge.
// Backpressure: none needed; bytes are accepted on every cycle, back-to-back included, and ignored once loading is done.
//
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   i_rx_data, i_rx_done - received byte and its one-cycle valid pulse
//   o_addr, o_wr, o_data - program memory write port (all registered)
//   o_loading, o_done    - CPU hold while loading / sticky completion flag
module program_loader #(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16,
    parameter int BYTE_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BYTE_LENGTH-1:0] i_rx_data,
    input  logic                   i_rx_done,
    output logic [ADDR_LENGTH-1:0] o_addr,
    output logic                   o_wr,
    output logic [DATA_LENGTH-1:0] o_data,
    output logic                   o_loading,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_LENGTH-1:0] ADDR_LAST = '1;

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] addr_q, addr_d;
    logic [DATA_LENGTH-1:0] data_q, data_d;
    logic                   wr_q, wr_d;
    logic                   loading_q, loading_d;
    logic                   done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_HI;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            loading_q <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            loading_q <= loading_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        loading_d = loading_q;
        done_d    = done_q;

        case (state_q)
            WAIT_HI: begin
                if (i_rx_done) begin
                    data_d[DATA_LENGTH-1:BYTE_LENGTH] = i_rx_data;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (i_rx_done) begin
                    data_d[BYTE_LENGTH-1:0] = i_rx_data;
                    wr_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // The word is captured by memory on this edge, so the halt and
                // end-of-memory decisions look at the word being written now.
                if ((data_q == '0) || (addr_q == ADDR_LAST)) begin
                    loading_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    // A byte arriving during the write is the next word's high
                    // byte; it only lands in o_data after the write cycle ends.
                    if (i_rx_done) begin
                        data_d[DATA_LENGTH-1:BYTE_LENGTH] = i_rx_data;
                        state_d = WAIT_LO;
                    end else begin
                        state_d = WAIT_HI;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_HI;
            end
        endcase
    end

    assign o_addr    = addr_q;
    assign o_wr      = wr_q;
    assign o_data    = data_q;
    assign o_loading = loading_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default geometry
    logic        a_reset, a_rx_done;
    logic [7:0]  a_rx_data;
    logic [10:0] a_addr;
    logic        a_wr;
    logic [15:0] a_data;
    logic        a_loading, a_done;

    // DUT B: tiny 4-word memory for address exhaustion
    logic        b_reset, b_rx_done;
    logic [7:0]  b_rx_data;
    logic [1:0]  b_addr;
    logic        b_wr;
    logic [15:0] b_data;
    logic        b_loading, b_done;

    program_loader dut_a (
        .clk(clk), .reset(a_reset), .i_rx_data(a_rx_data), .i_rx_done(a_rx_done),
        .o_addr(a_addr), .o_wr(a_wr), .o_data(a_data), .o_loading(a_loading), .o_done(a_done)
    );

    program_loader #(.ADDR_LENGTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .i_rx_data(b_rx_data), .i_rx_done(b_rx_done),
        .o_addr(b_addr), .o_wr(b_wr), .o_data(b_data), .o_loading(b_loading), .o_done(b_done)
    );

    int checks = 0;
    int failures = 0;

    // Write logs: {addr padded to 16 bits, data}, captured mid-cycle.
    logic [31:0] log_a[$];
    logic [31:0] log_b[$];
    logic        a_wr_prev = 1'b0;
    int          a_wr_wide = 0;

    always @(negedge clk) begin
        if (a_wr) log_a.push_back({5'd0, a_addr, a_data});
        if (b_wr) log_b.push_back({14'd0, b_addr, b_data});
        if (a_wr && a_wr_prev) a_wr_wide++;
        a_wr_prev = a_wr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called aligned to a negedge; gap=0 gives back-to-back pulses.
    task automatic send_a(input logic [7:0] b, input int gap);
        a_rx_data = b;
        a_rx_done = 1'b1;
        @(negedge clk);
        a_rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] b, input int gap);
        b_rx_data = b;
        b_rx_done = 1'b1;
        @(negedge clk);
        b_rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic reset_a();
        a_reset = 1'b1;
        @(negedge clk);
        a_reset = 1'b0;
    endtask

    task automatic send_stream_a(input int gap);
        send_a(8'h10, gap); send_a(8'h01, gap);
        send_a(8'h20, gap); send_a(8'h02, gap);
        send_a(8'h08, gap); send_a(8'h00, gap);
        send_a(8'h00, gap); send_a(8'h00, gap);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream_a(input string pfx);
        chk({pfx, "_nwr"},    32'(log_a.size()), 32'd4);
        chk({pfx, "_w0"},     log_a[0], 32'h0000_1001);
        chk({pfx, "_w1"},     log_a[1], 32'h0001_2002);
        chk({pfx, "_w2"},     log_a[2], 32'h0002_0800);
        chk({pfx, "_w3"},     log_a[3], 32'h0003_0000);
        chk({pfx, "_done"},   32'(a_done), 32'd1);
        chk({pfx, "_load"},   32'(a_loading), 32'd0);
        chk({pfx, "_addr"},   32'(a_addr), 32'd3);
    endtask

    initial begin
        a_reset = 1'b1; a_rx_done = 1'b0; a_rx_data = 8'h00;
        b_reset = 1'b1; b_rx_done = 1'b0; b_rx_data = 8'h00;
        repeat (3) @(negedge clk);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset values
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_wr",   32'(a_wr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_load", 32'(a_loading), 32'd1);
        chk("rst_done", 32'(a_done), 32'd0);

        // Basic load with 16 idle cycles between bytes
        log_a.delete();
        send_stream_a(16);
        check_stream_a("basic");

        // Post-done inertness
        log_a.delete();
        for (int i = 0; i < 20; i++) send_a(8'(8'h40 + i), 1);
        repeat (3) @(negedge clk);
        chk("post_nwr",  32'(log_a.size()), 32'd0);
        chk("post_wr",   32'(a_wr), 32'd0);
        chk("post_addr", 32'(a_addr), 32'd3);
        chk("post_data", 32'(a_data), 32'd0);
        chk("post_done", 32'(a_done), 32'd1);
        chk("post_load", 32'(a_loading), 32'd0);

        // Reset after done
        reset_a();
        chk("rst2_addr", 32'(a_addr), 32'd0);
        chk("rst2_wr",   32'(a_wr), 32'd0);
        chk("rst2_load", 32'(a_loading), 32'd1);
        chk("rst2_done", 32'(a_done), 32'd0);

        // Back-to-back bytes
        log_a.delete();
        a_wr_wide = 0;
        send_stream_a(0);
        check_stream_a("b2b");
        chk("b2b_wr_width", 32'(a_wr_wide), 32'd0);

        // Reset mid-word abandons the pending high byte
        reset_a();
        log_a.delete();
        send_a(8'h12, 2);
        reset_a();
        send_a(8'h34, 3); send_a(8'h56, 3);
        send_a(8'h00, 3); send_a(8'h00, 3);
        repeat (4) @(negedge clk);
        chk("mid_nwr",  32'(log_a.size()), 32'd2);
        chk("mid_w0",   log_a[0], 32'h0000_3456);
        chk("mid_w1",   log_a[1], 32'h0001_0000);
        chk("mid_done", 32'(a_done), 32'd1);
        chk("mid_addr", 32'(a_addr), 32'd1);

        // Address exhaustion on the 4-word instance
        log_b.delete();
        for (int i = 0; i < 10; i++) begin
            send_b(8'hAB, 1);
            send_b(8'hCD, 1);
        end
        repeat (4) @(negedge clk);
        chk("exh_nwr", 32'(log_b.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("exh_w%0d", i), log_b[i], {14'd0, 2'(i), 16'hABCD});
        chk("exh_done", 32'(b_done), 32'd1);
        chk("exh_load", 32'(b_loading), 32'd0);
        chk("exh_addr", 32'(b_addr), 32'd3);
        chk("exh_wr",   32'(b_wr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Fills the instruction program memory at boot from a byte stream delivered by the UART receiver. It assembles consecutive byte pairs into 16-bit instruction words and writes them to sequential memory addresses through the memory's write port (address, write strobe, write data). It holds the CPU off via `o_loading` until the Halt word (16'h0000) has been stored or the address space is exhausted. It sits between the UART receiver and the program memory, and its outputs are muxed onto the memory port while `o_loading` is high.

## Interface

Parameters:
- `ADDR_LENGTH`, default 11: program memory address width; depth is 2^ADDR_LENGTH words.
- `DATA_LENGTH`, default 16: instruction word width. Fixed at 16, two bytes per word.
- `BYTE_LENGTH`, default 8: width of the UART receive data.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_rx_data`  in  BYTE_LENGTH  received byte; valid only in the cycle `i_rx_done` is high.
- `i_rx_done`  in  1  one-cycle pulse meaning a byte is available.
- `o_addr`  out  ADDR_LENGTH  program memory write address.
- `o_wr`  out  1  memory write strobe; one-cycle pulse per word.
- `o_data`  out  DATA_LENGTH  instruction word to write.
- `o_loading`  out  1  high while loading; the CPU is held and the memory port belongs to the loader.
- `o_done`  out  1  high once loading has finished; sticky until reset.

## Operation

- States:
  - `WAIT_HI`: waiting for the high byte.
  - `WAIT_LO`: waiting for the low byte.
  - `WRITE`: write cycle.
  - `DONE`: loading finished.
- Byte order is big-endian: the first byte of each pair is bits [15:8], the second is bits [7:0].
- On `reset`:
  - State goes to `WAIT_HI`.
  - `o_addr` = 0, `o_data` = 0, `o_wr` = 0, `o_loading` = 1, `o_done` = 0.
- `WAIT_HI`: when `i_rx_done` = 1, latch `i_rx_data` into `o_data[15:8]` and go to `WAIT_LO`.
- `WAIT_LO`: when `i_rx_done` = 1:
  - Latch `i_rx_data` into `o_data[7:0]`.
  - Set `o_wr` = 1 and go to `WRITE`.
- `WRITE` (lasts exactly one cycle, with `o_wr` = 1). On the next edge `o_wr` = 0, then:
  - If `o_data` == 16'h0000 (Halt) or `o_addr` == 2^ADDR_LENGTH−1: go to `DONE`, `o_addr` holds, `o_loading` = 0, `o_done` = 1.
  - Otherwise: `o_addr` = `o_addr` + 1 and go to `WAIT_HI`.
  - If `i_rx_done` = 1 during the `WRITE` cycle, that byte is the next high byte. Latch it into the high-byte holding register and go to `WAIT_LO`, so no byte is dropped.
  - The write-cycle `o_data` is not disturbed; the next word's high byte is transferred into `o_data[15:8]` on the edge leaving `WRITE`.
- `DONE`:
  - `i_rx_done` is ignored.
  - `o_wr` stays 0.
  - All outputs hold until `reset`.
- The Halt word is written to memory before `DONE` is entered.
- The address never wraps. At address 2^ADDR_LENGTH−1 the word is written and loading ends, whatever its value.
- `reset` mid-load abandons any partial word and restarts at address 0. Words already written are not erased.

## Timing

- All outputs are registered; none is combinationally driven from the inputs.
- The low-byte `i_rx_done` is sampled at edge N:
  - `o_wr` = 1 in cycle N+1, with `o_addr` and `o_data` stable for that whole cycle.
  - The memory captures the word at edge N+2.
- `o_addr` increments at edge N+2, after the write has completed.
- `o_loading` falls and `o_done` rises at edge N+2 after a Halt write.
- Minimum byte spacing supported is 1 cycle, i.e. back-to-back `i_rx_done` pulses. No byte is lost at any spacing.
- Worst-case throughput: one word every 2 cycles.

## Test plan

- **Basic load.** Bytes 10 01, 20 02, 08 00, 00 00 with 16 idle cycles between pulses → four `o_wr` pulses:
  - addr 0 = 16'h1001, addr 1 = 16'h2002, addr 2 = 16'h0800, addr 3 = 16'h0000.
  - Then `o_done` = 1, `o_loading` = 0, `o_addr` = 3.
- **Back-to-back bytes.** The same stream with `i_rx_done` high on consecutive cycles → the same four writes, each `o_wr` one cycle wide, and no byte lost or reordered.
- **Address exhaustion.** With ADDR_LENGTH = 2, send 10 non-zero words (e.g. 16'hABCD) → exactly 4 writes at addresses 0..3, then `DONE` with `o_addr` = 3, and the remaining bytes produce no `o_wr`.
- **Reset mid-word.** Send high byte 8'h12, assert `reset` for 1 cycle, then send 34 56 00 00 → addr 0 = 16'h3456, addr 1 = 16'h0000, `o_done` = 1. The byte 8'h12 never appears in a write.
- **Post-done inertness and reset values.**
  - After `DONE`, send 20 bytes → `o_wr` stays 0 and the outputs hold.
  - Assert `reset` → next cycle `o_addr` = 0, `o_wr` = 0, `o_loading` = 1, `o_done` = 0.
